watch_display_scan: RTL and testbench



---
 rtl/watch_display_scan_pkg.sv | 28 ++
 rtl/watch_display_scan_if.sv | 27 ++
 rtl/watch_display_scan_bcd_to_seg7.sv | 27 ++
 rtl/watch_display_scan.sv | 115 +++++++++++
 tb/tb_watch_display_scan.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/watch_display_scan_pkg.sv
// Shared types and constants for the 6-digit multiplexed watch display.
package watch_display_scan_pkg;

   typedef logic [6:0] seg7_t;   // {g,f,e,d,c,b,a}, active-high

   localparam seg7_t SEG_0    = 7'h3F;
   localparam seg7_t SEG_1    = 7'h06;
   localparam seg7_t SEG_2    = 7'h5B;
   localparam seg7_t SEG_3    = 7'h4F;
   localparam seg7_t SEG_4    = 7'h66;
   localparam seg7_t SEG_5    = 7'h6D;
   localparam seg7_t SEG_6    = 7'h7D;
   localparam seg7_t SEG_7    = 7'h07;
   localparam seg7_t SEG_8    = 7'h7F;
   localparam seg7_t SEG_9    = 7'h6F;
   localparam seg7_t SEG_DASH = 7'h40;

   // Digit slots, rightmost first; also the dig_en bit position.
   localparam logic [2:0] IDX_SEC_1   = 3'd0;
   localparam logic [2:0] IDX_SEC_10  = 3'd1;
   localparam logic [2:0] IDX_MIN_1   = 3'd2;
   localparam logic [2:0] IDX_MIN_10  = 3'd3;
   localparam logic [2:0] IDX_HOUR_1  = 3'd4;
   localparam logic [2:0] IDX_HOUR_10 = 3'd5;

   localparam int NUM_DIGITS = 6;

endpackage

// File: rtl/watch_display_scan_if.sv
// Time digits in from the counter chain, segment/digit drive out to the display.
interface watch_display_scan_if;
   import watch_display_scan_pkg::*;

   logic [3:0] sec_1;
   logic [2:0] sec_10;
   logic [3:0] min_1;
   logic [2:0] min_10;
   logic [3:0] hour_1;
   logic [1:0] hour_10;
   seg7_t      seg;
   logic       dp;
   logic [5:0] dig_en;

   // Time source side: drives the digits, observes the display drive.
   modport master (
      output sec_1, sec_10, min_1, min_10, hour_1, hour_10,
      input  seg, dp, dig_en
   );

   // Scanner side.
   modport slave (
      input  sec_1, sec_10, min_1, min_10, hour_1, hour_10,
      output seg, dp, dig_en
   );

endinterface

// File: rtl/watch_display_scan_bcd_to_seg7.sv
// BCD digit to 7-segment pattern; anything above 9 shows a dash.
module bcd_to_seg7
   import watch_display_scan_pkg::*;
(
   input  logic [3:0] bcd,
   output seg7_t      seg
);

   // Pure lookup.
   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/watch_display_scan.sv
// Time-multiplexed scanner for a 6-digit common-cathode display. The time is
// snapshotted once per frame so a frame never mixes old and new digits.
module watch_display_scan
   import watch_display_scan_pkg::*;
#(
   parameter int SCAN_DIV  = 1000,
   parameter int BLANK_CYC = 2,
   parameter int LZ_BLANK  = 1
)(
   input  logic                 clk,
   input  logic                 rst,
   watch_display_scan_if.slave  bus
);

   localparam int              P_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [P_W-1:0]  P_LAST  = P_W'(SCAN_DIV - 1);
   localparam logic [P_W-1:0]  P_BLANK = P_W'(BLANK_CYC);

   logic [P_W-1:0] p;
   logic [2:0]     idx;

   logic [3:0] snap_sec_1;
   logic [2:0] snap_sec_10;
   logic [3:0] snap_min_1;
   logic [2:0] snap_min_10;
   logic [3:0] snap_hour_1;
   logic [1:0] snap_hour_10;

   logic [3:0] digit;
   seg7_t      seg_nxt;
   logic       blank_digit;
   logic [5:0] en_nxt;
   logic       dp_nxt;

   seg7_t      seg_q;
   logic       dp_q;
   logic [5:0] en_q;

   // Slot prescaler, digit index and per-frame snapshot; the snapshot loads on
   // the same edge idx wraps so slot 0 already shows the new time.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p            <= '0;
         idx          <= IDX_SEC_1;
         snap_sec_1   <= '0;
         snap_sec_10  <= '0;
         snap_min_1   <= '0;
         snap_min_10  <= '0;
         snap_hour_1  <= '0;
         snap_hour_10 <= '0;
      end else if (p == P_LAST) begin
         p <= '0;
         if (idx == IDX_HOUR_10) begin
            idx          <= IDX_SEC_1;
            snap_sec_1   <= bus.sec_1;
            snap_sec_10  <= bus.sec_10;
            snap_min_1   <= bus.min_1;
            snap_min_10  <= bus.min_10;
            snap_hour_1  <= bus.hour_1;
            snap_hour_10 <= bus.hour_10;
         end else begin
            idx <= idx + 3'd1;
         end
      end else begin
         p <= p + 1'b1;
      end
   end

   // Pick the snapshot digit for the current slot, zero-extended.
   always_comb begin
      digit = 4'd0;
      case (idx)
         IDX_SEC_1:   digit = snap_sec_1;
         IDX_SEC_10:  digit = {1'b0, snap_sec_10};
         IDX_MIN_1:   digit = snap_min_1;
         IDX_MIN_10:  digit = {1'b0, snap_min_10};
         IDX_HOUR_1:  digit = snap_hour_1;
         IDX_HOUR_10: digit = {2'b00, snap_hour_10};
         default:     digit = 4'd0;
      endcase
   end

   bcd_to_seg7 u_dec (
      .bcd (digit),
      .seg (seg_nxt)
   );

   // Enable is held off at the start of every slot to stop ghosting, and for the
   // whole slot when a leading zero on the hours-tens digit is suppressed.
   always_comb begin
      blank_digit = (LZ_BLANK != 0) && (idx == IDX_HOUR_10) && (snap_hour_10 == 2'd0);
      en_nxt      = 6'b0;
      if ((p >= P_BLANK) && !blank_digit)
         en_nxt = 6'b1 << idx;
      dp_nxt = ((idx == IDX_MIN_1) || (idx == IDX_HOUR_1)) && !snap_sec_1[0];
   end

   // Registered display drive; one cycle behind the scan state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg_q <= '0;
         dp_q  <= 1'b0;
         en_q  <= '0;
      end else begin
         seg_q <= seg_nxt;
         dp_q  <= dp_nxt;
         en_q  <= en_nxt;
      end
   end

   assign bus.seg    = seg_q;
   assign bus.dp     = dp_q;
   assign bus.dig_en = en_q;

endmodule

// File: tb/tb_watch_display_scan.sv
// Bench for watch_display_scan: random time inputs, outputs compared every
// cycle against a model built from the elapsed cycle count since reset.
module tb_watch_display_scan;

   localparam int SD    = 4;
   localparam int BC    = 1;
   localparam int LZ    = 1;
   localparam int FRAME = 6 * SD;

   logic clk = 1'b0;
   logic rst = 1'b0;

   watch_display_scan_if bus ();

   watch_display_scan #(
      .SCAN_DIV  (SD),
      .BLANK_CYC (BC),
      .LZ_BLANK  (LZ)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // cur: what is being driven now; snap: what the model says is displayed.
   // Index 0..5 = sec_1, sec_10, min_1, min_10, hour_1, hour_10.
   int cur  [6];
   int snap [6];
   int e;   // rising edges since reset release

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'h3F;
         1: return 7'h06;
         2: return 7'h5B;
         3: return 7'h4F;
         4: return 7'h66;
         5: return 7'h6D;
         6: return 7'h7D;
         7: return 7'h07;
         8: return 7'h7F;
         9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   task automatic drive();
      bus.sec_1   = 4'(cur[0]);
      bus.sec_10  = 3'(cur[1]);
      bus.min_1   = 4'(cur[2]);
      bus.min_10  = 3'(cur[3]);
      bus.hour_1  = 4'(cur[4]);
      bus.hour_10 = 2'(cur[5]);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_seg"},    32'(bus.seg),    32'd0);
      chk({tag, "_dp"},     32'(bus.dp),     32'd0);
      chk({tag, "_dig_en"}, 32'(bus.dig_en), 32'd0);
   endtask

   // One clock: outputs after edge e reflect scan position n = e-1.
   task automatic step();
      int n, p, idx;
      logic [6:0] exp_seg;
      logic [5:0] exp_en;
      logic       exp_dp;
      @(posedge clk);
      e++;
      n   = e - 1;
      p   = n % SD;
      idx = (n / SD) % 6;
      exp_seg = seg_of(snap[idx]);
      exp_en  = 6'd0;
      if (p >= BC && !(LZ != 0 && idx == 5 && snap[5] == 0))
         exp_en = 6'd1 << idx;
      exp_dp = (idx == 2 || idx == 4) && (snap[0] % 2 == 0);
      if (e % FRAME == 0)
         for (int i = 0; i < 6; i++) snap[i] = cur[i];
      #1;
      chk($sformatf("seg_i%0d_p%0d", idx, p),    32'(bus.seg),    32'(exp_seg));
      chk($sformatf("dp_i%0d_p%0d", idx, p),     32'(bus.dp),     32'(exp_dp));
      chk($sformatf("dig_en_i%0d_p%0d", idx, p), 32'(bus.dig_en), 32'(exp_en));
   endtask

   task automatic mutate(input int f);
      if (f == 1) begin
         cur[5] = 0; cur[4] = 9; cur[0] = 7;
      end else if (f == 2) begin
         cur[0] = 12;
      end else begin
         cur[0] = $urandom_range(0, 15);
         cur[1] = $urandom_range(0, 7);
         cur[2] = $urandom_range(0, 15);
         cur[3] = $urandom_range(0, 7);
         cur[4] = $urandom_range(0, 15);
         cur[5] = $urandom_range(0, 3);
      end
      drive();
   endtask

   initial begin
      // 12:34:56 held during reset
      cur[0] = 6; cur[1] = 5; cur[2] = 4; cur[3] = 3; cur[4] = 2; cur[5] = 1;
      for (int i = 0; i < 6; i++) snap[i] = 0;
      drive();
      rst = 1'b0;
      e   = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check_zero("reset_hold");
      end
      rst = 1'b1;

      // Frame 0 zeros, frame 1 12:34:56, frame 2 leading-zero/odd seconds,
      // frame 3 invalid BCD, later frames random; changes land mid-frame in slot 2.
      for (int f = 0; f < 24; f++) begin
         for (int c = 0; c < FRAME; c++) begin
            step();
            if (f >= 1 && c == 2 * SD + 1) mutate(f);
         end
      end

      // Abort the scan in slot 3 with a one-cycle reset.
      for (int c = 0; c < 3 * SD + 1; c++) step();
      rst = 1'b0;
      #1;
      check_zero("reset_async");
      @(posedge clk);
      #1;
      check_zero("reset_mid");
      rst = 1'b1;
      e   = 0;
      for (int i = 0; i < 6; i++) snap[i] = 0;

      for (int f = 0; f < 4; f++) begin
         for (int c = 0; c < FRAME; c++) begin
            step();
            if (f >= 1 && c == 2 * SD + 1) mutate(3 + f);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
